cpu_ctrl: RTL and testbench

Instruction register and finite-state controller that sequences the lab datapath one instruction at a time. It latches a 16-bit instruction, decodes its fields and drives the register-file ports (readnum, writenum, write) plus the datapath load, select and ALU controls, one state per cycle. It sits directly upstream of the register file and datapath, and feeds them all read/write indices and strobes.

---
 rtl/cpu_ctrl.sv | 145 ++++++++++++++
 tb/tb_cpu_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl.sv
// Instruction register plus Moore FSM sequencing the lab datapath one instruction at a time.
// Optional CPU_CTRL_ILLEGAL_TRAP_EN: unsupported encodings lock into TRAP until reset.
module cpu_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] in,
   input  logic        load,
   input  logic        s,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        loada,
   output logic        loadb,
   output logic        loadc,
   output logic        loads,
   output logic        asel,
   output logic        bsel,
   output logic [1:0]  vsel,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [15:0] sximm5,
   output logic [15:0] sximm8,
   output logic        illegal
);

   typedef enum logic [2:0] {
      StWait, StDecode, StWriteImm, StGetA, StGetB, StAluOp, StWriteReg
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      , StTrap
`endif
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] ir_q, ir_d;

   logic [2:0] opcode;
   logic [1:0] op;
   logic       is_mov_imm, is_mov_reg, is_alu, is_cmp;

   assign opcode     = ir_q[15:13];
   assign op         = ir_q[12:11];
   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);

   assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
   assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
   assign ALUop  = is_alu ? op : 2'b00;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StWait;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // IR only accepts a new word while idle; DECODE sees it when load and s coincide.
   always_comb begin
      ir_d = ir_q;
      if ((state_q == StWait) && load) ir_d = in;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StWait:     if (s) state_d = StDecode;
         StDecode: begin
            if (is_mov_imm)      state_d = StWriteImm;
            else if (is_mov_reg) state_d = StGetB;
            else if (is_alu)     state_d = StGetA;
            else begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
               state_d = StTrap;
`else
               state_d = StWait;
`endif
            end
         end
         StWriteImm: state_d = StWait;
         StGetA:     state_d = StGetB;
         StGetB:     state_d = StAluOp;
         StAluOp:    state_d = is_cmp ? StWait : StWriteReg;
         StWriteReg: state_d = StWait;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
         StTrap:     state_d = StTrap;
`endif
         default:    state_d = StWait;
      endcase
   end

   always_comb begin
      w        = 1'b0;
      readnum  = 3'd0;
      writenum = 3'd0;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      vsel     = 2'b00;
      shift    = 2'b00;
      case (state_q)
         StWait:     w = 1'b1;
         StWriteImm: begin
            writenum = ir_q[10:8];
            vsel     = 2'b10;
            write    = 1'b1;
         end
         StGetA: begin
            readnum = ir_q[10:8];
            loada   = 1'b1;
         end
         StGetB: begin
            readnum = ir_q[2:0];
            loadb   = 1'b1;
            shift   = ir_q[4:3];
         end
         StAluOp: begin
            shift = ir_q[4:3];
            asel  = is_mov_reg;
            loads = is_cmp;
            loadc = !is_cmp;
         end
         StWriteReg: begin
            writenum = ir_q[7:5];
            write    = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
   assign illegal = (state_q == StTrap);
`else
   assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: per-cycle expected outputs queued at drive time, checked at negedge.
module tb_cpu_ctrl;

   localparam int SW = 0, SD = 1, SI = 2, SA = 3, SB = 4, SU = 5, SR = 6, ST = 7;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] in;
   logic        load, s;
   logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, shift, ALUop;
   logic [15:0] sximm5, sximm8;

   logic [52:0] obs;
   logic [52:0] exp_q[$];
   string       tag_q[$];
   logic [15:0] model_ir = 16'h0000;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   cpu_ctrl dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in       (in),
      .load     (load),
      .s        (s),
      .w        (w),
      .readnum  (readnum),
      .writenum (writenum),
      .write    (write),
      .loada    (loada),
      .loadb    (loadb),
      .loadc    (loadc),
      .loads    (loads),
      .asel     (asel),
      .bsel     (bsel),
      .vsel     (vsel),
      .shift    (shift),
      .ALUop    (ALUop),
      .sximm5   (sximm5),
      .sximm8   (sximm8),
      .illegal  (illegal)
   );

   assign obs = {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
                 vsel, shift, ALUop, illegal, sximm5, sximm8};

   task automatic check(input string tag, input logic [52:0] act, input logic [52:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Expected Moore outputs for a state, built from the instruction-field table.
   function automatic logic [52:0] exp_out(input int st, input logic [15:0] ir);
      logic       ew, ewr, ela, elb, elc, els, eas, eill;
      logic [2:0] ern, ewn;
      logic [1:0] evs, esh, ealu;
      ew = 0; ewr = 0; ela = 0; elb = 0; elc = 0; els = 0; eas = 0; eill = 0;
      ern = 0; ewn = 0; evs = 0; esh = 0;
      ealu = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
      case (st)
         SW: ew = 1;
         SI: begin ewn = ir[10:8]; evs = 2'b10; ewr = 1; end
         SA: begin ern = ir[10:8]; ela = 1; end
         SB: begin ern = ir[2:0]; elb = 1; esh = ir[4:3]; end
         SU: begin
            esh = ir[4:3];
            eas = (ir[15:13] == 3'b110);
            if (ir[15:11] == 5'b10101) els = 1;
            else elc = 1;
         end
         SR: begin ewn = ir[7:5]; ewr = 1; end
         ST: eill = 1;
         default: ;
      endcase
      return {ew, ern, ewn, ewr, ela, elb, elc, els, eas, 1'b0, evs, esh, ealu, eill,
              {{11{ir[4]}}, ir[4:0]}, {{8{ir[7]}}, ir[7:0]}};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) check(tag_q.pop_front(), obs, exp_q.pop_front());
   end

   task automatic tick(input logic ld, input logic st, input logic [15:0] din, input int exp_st,
                       input string name);
      @(posedge clk);
      #1;
      load = ld;
      s    = st;
      in   = din;
      exp_q.push_back(exp_out(exp_st, model_ir));
      tag_q.push_back($sformatf("%s/st%0d", name, exp_st));
   endtask

   task automatic reset_pulse(input string name);
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      check({name, "_w"}, {52'd0, w}, 53'd1);
      check({name, "_illegal"}, {52'd0, illegal}, 53'd0);
      check({name, "_outs"}, obs, exp_out(SW, 16'h0000));
      @(posedge clk);
      #1 reset_n = 1'b1;
      model_ir = 16'h0000;
   endtask

   task automatic run_instr(input logic [15:0] instr, input string name, input bit together,
                            input bit busy_load);
      int  path[$];
      bit  bad;
      bad = 0;
      if (together) begin
         tick(1, 1, instr, SW, name);
         model_ir = instr;
      end else begin
         tick(1, 0, instr, SW, name);
         model_ir = instr;
         tick(0, 1, 16'h0000, SW, name);
      end
      if (instr[15:11] == 5'b11010)      path = '{SD, SI};
      else if (instr[15:11] == 5'b11000) path = '{SD, SB, SU, SR};
      else if (instr[15:11] == 5'b10101) path = '{SD, SA, SB, SU};
      else if (instr[15:13] == 3'b101)   path = '{SD, SA, SB, SU, SR};
      else begin
         path = '{SD};
         bad  = 1;
      end
      foreach (path[i]) begin
         if (busy_load && path[i] == SB) tick(1, 0, 16'hD007, SB, name);
         else tick(0, 0, 16'h0000, path[i], name);
      end
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      if (bad) begin
         repeat (3) tick(1, 1, 16'hD007, ST, name);
         reset_pulse({name, "_trap_rst"});
         return;
      end
`endif
      tick(0, 0, 16'h0000, SW, name);
   endtask

   initial begin
      reset_n = 1'b0;
      load    = 1'b0;
      s       = 1'b0;
      in      = 16'hFFFF;
      #1;
      check("reset_outs", obs, exp_out(SW, 16'h0000));
      #11 reset_n = 1'b1;

      run_instr(16'hD007, "mov_imm7", 0, 0);
      run_instr(16'hD1FE, "mov_immFE", 0, 0);
      run_instr(16'hA148, "add", 0, 0);
      run_instr(16'hA801, "cmp", 0, 0);
      run_instr(16'hC062, "mov_reg", 0, 0);
      run_instr(16'hA148, "add_busyload", 0, 1);
      run_instr(16'hB8A3, "mvn", 0, 0);
      run_instr(16'hB2E9, "and", 0, 0);
      run_instr(16'hC27A, "movreg_together", 1, 0);
      run_instr(16'hE000, "illegal_e000", 0, 0);
      run_instr(16'hC800, "illegal_c800", 1, 0);

      // Abort ADD asynchronously while in GET_A.
      tick(1, 0, 16'hA148, SW, "abort");
      model_ir = 16'hA148;
      tick(0, 1, 16'h0000, SW, "abort");
      tick(0, 0, 16'h0000, SD, "abort");
      tick(0, 0, 16'h0000, SA, "abort");
      reset_pulse("abort_rst");
      repeat (3) tick(0, 0, 16'h0000, SW, "after_abort");
      run_instr(16'hD1FE, "post_abort", 0, 0);

      @(negedge clk);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
